// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_pkg
//  Purpose  : Shared width, capture FSM state encoding and sample conversion
//             for the triggered ADC capture buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package adc_capture_pkg;

    localparam int DATA_W = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } state_t;

    // Offset binary to two's complement is a flip of the MSB.
    function automatic logic [DATA_W-1:0] ob_to_tc(input logic [DATA_W-1:0] raw);
        return {~raw[DATA_W-1], raw[DATA_W-2:0]};
    endfunction

endpackage : adc_capture_pkg
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// ============================================================================
//  Module   : capture_ram
//  Purpose  : Simple dual-port record RAM, synchronous write, registered read.
//  Revision : 1.0 - initial release
// ============================================================================
module capture_ram
    import adc_capture_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata_q;

endmodule : capture_ram
`default_nettype wire

// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture
//  Purpose  : Decimating, level-triggered single-shot capture of the ADC-A
//             stream into RAM, streamed back out over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_in,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [7:0]        decim,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] C_ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   C_RD_END    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_RD_ONE    = (AW+1)'(1);

    state_t            r_state_q, w_state_d;
    logic [DATA_W-1:0] r_s_q, w_s_d;
    logic [DATA_W-1:0] r_level_q, w_level_d;
    logic              r_slope_q, w_slope_d;
    logic [7:0]        r_decim_q, w_decim_d;
    logic [7:0]        r_cnt_q, w_cnt_d;
    logic [DATA_W-1:0] r_prev_q, w_prev_d;
    logic              r_prev_valid_q, w_prev_valid_d;
    logic              r_force_q, w_force_d;
    logic [AW-1:0]     r_wptr_q, w_wptr_d;
    logic [AW:0]       r_ridx_q, w_ridx_d;
    logic [AW-1:0]     r_hcnt_q, w_hcnt_d;
    logic              r_v1_q, w_v1_d;
    logic              r_rd_valid_q, w_rd_valid_d;
    logic [DATA_W-1:0] r_rd_data_q, w_rd_data_d;
    logic              r_done_q, w_done_d;

    logic              w_strobe, w_rise, w_fall, w_hit;
    logic              w_we, w_re, w_out_free, w_hs;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_ram_q;

    capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (r_s_q),
        .i_re    (w_re),
        .i_raddr (r_ridx_q[AW-1:0]),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_s_d          = ob_to_tc(adc_in);
        w_level_d      = r_level_q;
        w_slope_d      = r_slope_q;
        w_decim_d      = r_decim_q;
        w_cnt_d        = r_cnt_q;
        w_prev_d       = r_prev_q;
        w_prev_valid_d = r_prev_valid_q;
        w_force_d      = r_force_q;
        w_wptr_d       = r_wptr_q;
        w_ridx_d       = r_ridx_q;
        w_hcnt_d       = r_hcnt_q;
        w_v1_d         = r_v1_q;
        w_rd_valid_d   = r_rd_valid_q;
        w_rd_data_d    = r_rd_data_q;
        w_done_d       = 1'b0;
        w_we           = 1'b0;
        w_waddr        = r_wptr_q;

        // Decimator runs uniformly through ARMED and CAPTURE so spacing is kept
        // across the trigger boundary.
        w_strobe = ((r_state_q == ARMED) || (r_state_q == CAPTURE)) && (r_cnt_q == 8'd0);
        if (w_strobe) begin
            w_cnt_d = r_decim_q;
        end else if ((r_state_q == ARMED) || (r_state_q == CAPTURE)) begin
            w_cnt_d = r_cnt_q - 8'd1;
        end

        w_rise = ($signed(r_prev_q) < $signed(r_level_q)) && ($signed(r_s_q) >= $signed(r_level_q));
        w_fall = ($signed(r_prev_q) > $signed(r_level_q)) && ($signed(r_s_q) <= $signed(r_level_q));
        w_hit  = r_slope_q ? w_rise : w_fall;

        // Readout: RAM output stage (v1) feeds the output register; a new read is
        // issued only when the RAM stage is empty or drains this cycle.
        w_out_free = !r_rd_valid_q || rd_ready;
        w_hs       = r_rd_valid_q && rd_ready;
        w_re       = (r_state_q == READOUT) && (r_ridx_q != C_RD_END) && (!r_v1_q || w_out_free);
        if (w_re) begin
            w_ridx_d = r_ridx_q + C_RD_ONE;
            w_v1_d   = 1'b1;
        end else if (w_out_free) begin
            w_v1_d   = 1'b0;
        end
        if (w_out_free) begin
            w_rd_valid_d = r_v1_q;
            if (r_v1_q) begin
                w_rd_data_d = w_ram_q;
            end
        end

        case (r_state_q)
            IDLE: begin
                if (arm && !r_done_q) begin
                    w_state_d      = ARMED;
                    w_level_d      = trig_level;
                    w_slope_d      = trig_slope;
                    w_decim_d      = decim;
                    w_cnt_d        = 8'd0;
                    w_prev_valid_d = 1'b0;
                    w_force_d      = 1'b0;
                    w_wptr_d       = '0;
                end
            end
            ARMED: begin
                w_force_d = r_force_q || force_trig;
                if (w_strobe) begin
                    if (r_force_q || force_trig || (r_prev_valid_q && w_hit)) begin
                        w_we      = 1'b1;
                        w_waddr   = '0;
                        w_wptr_d  = C_ADDR_ONE;
                        w_state_d = CAPTURE;
                    end else begin
                        w_prev_d       = r_s_q;
                        w_prev_valid_d = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (w_strobe) begin
                    w_we     = 1'b1;
                    w_wptr_d = r_wptr_q + C_ADDR_ONE;
                    if (r_wptr_q == C_LAST_ADDR) begin
                        w_state_d = READOUT;
                        w_ridx_d  = '0;
                        w_hcnt_d  = '0;
                    end
                end
            end
            READOUT: begin
                if (w_hs) begin
                    w_hcnt_d = r_hcnt_q + C_ADDR_ONE;
                    if (r_hcnt_q == C_LAST_ADDR) begin
                        w_state_d = IDLE;
                        w_done_d  = 1'b1;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= IDLE;
            r_s_q          <= '0;
            r_level_q      <= '0;
            r_slope_q      <= 1'b0;
            r_decim_q      <= 8'd0;
            r_cnt_q        <= 8'd0;
            r_prev_q       <= '0;
            r_prev_valid_q <= 1'b0;
            r_force_q      <= 1'b0;
            r_wptr_q       <= '0;
            r_ridx_q       <= '0;
            r_hcnt_q       <= '0;
            r_v1_q         <= 1'b0;
            r_rd_valid_q   <= 1'b0;
            r_rd_data_q    <= '0;
            r_done_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_s_q          <= w_s_d;
            r_level_q      <= w_level_d;
            r_slope_q      <= w_slope_d;
            r_decim_q      <= w_decim_d;
            r_cnt_q        <= w_cnt_d;
            r_prev_q       <= w_prev_d;
            r_prev_valid_q <= w_prev_valid_d;
            r_force_q      <= w_force_d;
            r_wptr_q       <= w_wptr_d;
            r_ridx_q       <= w_ridx_d;
            r_hcnt_q       <= w_hcnt_d;
            r_v1_q         <= w_v1_d;
            r_rd_valid_q   <= w_rd_valid_d;
            r_rd_data_q    <= w_rd_data_d;
            r_done_q       <= w_done_d;
        end
    end

    assign rd_data  = r_rd_data_q;
    assign rd_valid = r_rd_valid_q;
    assign busy     = (r_state_q != IDLE);
    assign done     = r_done_q;

endmodule : adc_capture
`default_nettype wire
